pe_mac_acc: RTL
===============

PE_MAC_ACC -- requirements
Module: pe_mac_acc

Interface
REQ-001 SHALL have parameter DWD, default 16, meaning pixel word width in bits; legal values are multiples of 16.
REQ-002 SHALL have parameter ACCWD, default 32, meaning accumulator and output width in bits; minimum 18.
REQ-003 SHALL have parameter LENWD, default 8, meaning width of the beat-count configuration field.
REQ-004 SHALL derive PSWD = 18 + $clog2(DWD/16), the signed width of the per-beat partial sum.
REQ-005 Ports, in order:
- i_clk  in  1  clock. One clock; reset is synchronous and active-high.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  begin a group; sampled only in IDLE.
- i_mode  in  3  0=XNOR, 1=M1, 2=M2, 3=M4, 4=M8; codes 5-7 act as M8.
- i_isgn  in  1  input pixels signed.
- i_wsgn  in  1  weight pixels signed.
- i_len  in  LENWD  beats per group; 0 acts as 1.
- i_valid  in  1  beat valid.
- o_ready  out  1  beat accepted when i_valid && o_ready.
- i_ipix  in  DWD  input pixel word.
- i_wpix  in  DWD  weight word.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream ready.
- o_acc  out  ACCWD  signed accumulated result.
- o_sat  out  1  saturation occurred in this group.
- o_busy  out  1  high whenever the state is not IDLE.

Function
REQ-006 SHALL implement the FSM IDLE -> ACC -> DRAIN -> OUT -> IDLE.
- IDLE->ACC on i_start; latch mode, isgn, wsgn and len; clear acc, o_sat and the beat counter.
- ACC->DRAIN at the edge accepting the last beat.
- DRAIN->OUT at the next edge, when the final partial sum is added.
- OUT->IDLE on o_valid && i_ready.
REQ-007 i_start outside IDLE SHALL be ignored, and configuration SHALL NOT change mid-group.
REQ-008 o_ready SHALL be 1 only in ACC; the beat counter increments on each accepted beat.
REQ-009 Partial sum, registered at the acceptance edge:
- XNOR: 2*popcount(~(ipix^wpix)) - DWD.
- M1: popcount(ipix&wpix), negated when isgn != wsgn.
- M2/M4/M8: sum over the DWD/2, DWD/4 and DWD/8 lanes of ipix_lane*wpix_lane. Each operand is sign-extended when its flag is set, zero-extended otherwise.
- All results are sign-extended to PSWD.
REQ-010 The registered partial sum SHALL be added to acc at the following edge.
- Back-to-back beats SHALL be accepted every cycle (2-stage pipeline, no bubbles).
REQ-011 Accumulation SHALL saturate to the signed ACCWD range (max 2^(ACCWD-1)-1, min -2^(ACCWD-1)).
- On saturation, set o_sat, which is sticky until the next i_start.
REQ-012 o_valid SHALL be 1 only in OUT, first at the second rising edge after the last beat's acceptance edge.
REQ-013 While o_valid && !i_ready, o_acc and o_sat SHALL hold stable.
REQ-014 i_valid without o_ready SHALL have no effect.
- Input data is don't-care when i_valid=0.

Reset
REQ-015 With i_rst high at a rising edge, the following SHALL hold regardless of state, discarding any partial group:
- state=IDLE.
- o_valid=0, o_ready=0, o_busy=0.
- o_acc=0, o_sat=0.
- Internal counter and pipeline valid = 0.
REQ-016 i_start coincident with i_rst SHALL be ignored.

Verification
REQ-017 M8 unsigned, len=1, ipix=wpix=0xFFFF -> o_acc=130050, o_sat=0; o_valid 2 edges after acceptance.
REQ-018 XNOR, len=2, beat0 ipix=wpix=0xFFFF (+16), beat1 ipix=0x0000/wpix=0xFFFF (-16) -> o_acc=0.
REQ-019 M4 signed/signed, len=3, ipix=0x8888, wpix=0x7777, i_valid toggling 1/0 -> o_acc=-672.
- No beat is lost or duplicated.
REQ-020 ACCWD=18, M8 unsigned, len=4, ipix=wpix=0xFFFF -> o_acc=131071, o_sat=1.
REQ-021 i_ready low 5 cycles in OUT -> o_acc stable, o_ready=0, i_start ignored; IDLE one edge after i_ready rises.
REQ-022 i_rst asserted after 2 of 4 beats -> all outputs 0 next cycle.
- A fresh len=1 M2 group (ipix=wpix=0x5555, unsigned) -> o_acc=8.

Source files
------------

// File: rtl/pe_mac_acc.sv
// Processing-element multiply/accumulate over a group of beats.
// Each accepted beat produces a partial sum (XNOR, 1/2/4/8-bit lane products),
// registered at the acceptance edge and added into a saturating accumulator on
// the next edge. The result is presented with a valid/ready handshake.
module pe_mac_acc #(
   parameter int DWD   = 16,
   parameter int ACCWD = 32,
   parameter int LENWD = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [2:0]       i_mode,
   input  logic             i_isgn,
   input  logic             i_wsgn,
   input  logic [LENWD-1:0] i_len,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [DWD-1:0]   i_ipix,
   input  logic [DWD-1:0]   i_wpix,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [ACCWD-1:0] o_acc,
   output logic             o_sat,
   output logic             o_busy
);

   localparam int PSWD = 18 + $clog2(DWD / 16);
   // Adder width large enough that neither operand can wrap before saturation.
   localparam int SUMW = ((ACCWD > PSWD) ? ACCWD : PSWD) + 1;

   localparam logic signed [ACCWD-1:0] ACC_MAX = {1'b0, {(ACCWD-1){1'b1}}};
   localparam logic signed [ACCWD-1:0] ACC_MIN = {1'b1, {(ACCWD-1){1'b0}}};
   localparam logic [LENWD-1:0]        LEN_ONE = {{(LENWD-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACC   = 2'd1,
      S_DRAIN = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [2:0]               r_mode;
   logic                     r_isgn;
   logic                     r_wsgn;
   logic [LENWD-1:0]         r_len_m1;
   logic [LENWD-1:0]         r_cnt;
   logic signed [PSWD-1:0]   r_ps;
   logic                     r_ps_vld;
   logic signed [ACCWD-1:0]  r_acc;
   logic                     r_sat;

   logic                     w_accept;
   logic                     w_last;
   logic [DWD-1:0]           w_xnor_vec;
   logic [DWD-1:0]           w_and_vec;
   logic signed [PSWD-1:0]   w_pc_xnor;
   logic signed [PSWD-1:0]   w_pc_and;
   logic signed [PSWD-1:0]   w_sum2;
   logic signed [PSWD-1:0]   w_sum4;
   logic signed [PSWD-1:0]   w_sum8;
   logic signed [17:0]       w_prod;
   logic signed [PSWD-1:0]   w_ps;
   logic signed [SUMW-1:0]   w_acc_sum;
   logic signed [ACCWD-1:0]  w_acc_nxt;
   logic                     w_sat_hit;

   // Extend a lane of width w (held in the low bits of v) to 9 signed bits.
   function automatic logic signed [8:0] ext_lane(input logic [7:0] v, input int w, input logic sgn);
      logic [8:0] hi;
      logic [8:0] r;
      logic       msb;
      hi  = 9'h1FF << w;
      msb = |(v & (8'h01 << (w - 1)));
      if (sgn && msb) begin
         r = {1'b0, v} | hi;
      end else begin
         r = {1'b0, v};
      end
      return $signed(r);
   endfunction

   assign w_accept   = (r_state == S_ACC) && i_valid;
   assign w_last     = (r_cnt == r_len_m1);
   assign w_xnor_vec = ~(i_ipix ^ i_wpix);
   assign w_and_vec  = i_ipix & i_wpix;

   assign o_ready = (r_state == S_ACC);
   assign o_valid = (r_state == S_OUT);
   assign o_busy  = (r_state != S_IDLE);
   assign o_acc   = r_acc;
   assign o_sat   = r_sat;

   // Partial sum of the current beat for every mode, then select the latched mode.
   always_comb begin
      w_pc_xnor = '0;
      w_pc_and  = '0;
      w_sum2    = '0;
      w_sum4    = '0;
      w_sum8    = '0;
      w_prod    = '0;
      w_ps      = '0;
      for (int k = 0; k < DWD; k++) begin
         w_pc_xnor = w_pc_xnor + PSWD'(w_xnor_vec[k]);
         w_pc_and  = w_pc_and + PSWD'(w_and_vec[k]);
      end
      for (int i = 0; i < DWD / 2; i++) begin
         w_prod = ext_lane({6'd0, i_ipix[2*i +: 2]}, 2, r_isgn) *
                  ext_lane({6'd0, i_wpix[2*i +: 2]}, 2, r_wsgn);
         w_sum2 = w_sum2 + PSWD'(w_prod);
      end
      for (int i = 0; i < DWD / 4; i++) begin
         w_prod = ext_lane({4'd0, i_ipix[4*i +: 4]}, 4, r_isgn) *
                  ext_lane({4'd0, i_wpix[4*i +: 4]}, 4, r_wsgn);
         w_sum4 = w_sum4 + PSWD'(w_prod);
      end
      for (int i = 0; i < DWD / 8; i++) begin
         w_prod = ext_lane(i_ipix[8*i +: 8], 8, r_isgn) *
                  ext_lane(i_wpix[8*i +: 8], 8, r_wsgn);
         w_sum8 = w_sum8 + PSWD'(w_prod);
      end
      case (r_mode)
         3'd0:    w_ps = (w_pc_xnor + w_pc_xnor) - PSWD'(DWD);
         3'd1:    w_ps = (r_isgn ^ r_wsgn) ? -w_pc_and : w_pc_and;
         3'd2:    w_ps = w_sum2;
         3'd3:    w_ps = w_sum4;
         default: w_ps = w_sum8;
      endcase
   end

   // Saturating add of the registered partial sum into the accumulator.
   always_comb begin
      w_acc_sum = SUMW'(r_acc) + SUMW'(r_ps);
      w_acc_nxt = r_acc;
      w_sat_hit = 1'b0;
      if (w_acc_sum > SUMW'(ACC_MAX)) begin
         w_acc_nxt = ACC_MAX;
         w_sat_hit = 1'b1;
      end else if (w_acc_sum < SUMW'(ACC_MIN)) begin
         w_acc_nxt = ACC_MIN;
         w_sat_hit = 1'b1;
      end else begin
         w_acc_nxt = w_acc_sum[ACCWD-1:0];
         w_sat_hit = 1'b0;
      end
   end

   // Next-state logic for the group sequencer.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_state_nxt = S_ACC;
            else         w_state_nxt = S_IDLE;
         end
         S_ACC: begin
            if (w_accept && w_last) w_state_nxt = S_DRAIN;
            else                    w_state_nxt = S_ACC;
         end
         S_DRAIN: w_state_nxt = S_OUT;
         S_OUT: begin
            if (i_ready) w_state_nxt = S_IDLE;
            else         w_state_nxt = S_OUT;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Group configuration, captured only when a group starts.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mode   <= 3'd0;
         r_isgn   <= 1'b0;
         r_wsgn   <= 1'b0;
         r_len_m1 <= '0;
      end else if ((r_state == S_IDLE) && i_start) begin
         r_mode   <= i_mode;
         r_isgn   <= i_isgn;
         r_wsgn   <= i_wsgn;
         r_len_m1 <= (i_len == '0) ? '0 : (i_len - LEN_ONE);
      end
   end

   // Beat counter and first pipeline stage (registered partial sum).
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt    <= '0;
         r_ps     <= '0;
         r_ps_vld <= 1'b0;
      end else if ((r_state == S_IDLE) && i_start) begin
         r_cnt    <= '0;
         r_ps_vld <= 1'b0;
      end else begin
         r_ps_vld <= w_accept;
         if (w_accept) begin
            r_ps  <= w_ps;
            r_cnt <= r_cnt + LEN_ONE;
         end
      end
   end

   // Accumulator and sticky saturation flag; both hold while waiting in OUT.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_acc <= '0;
         r_sat <= 1'b0;
      end else if ((r_state == S_IDLE) && i_start) begin
         r_acc <= '0;
         r_sat <= 1'b0;
      end else if (r_ps_vld) begin
         r_acc <= w_acc_nxt;
         r_sat <= r_sat | w_sat_hit;
      end
   end

endmodule
